// File: rtl/opencl_stream_adapter_pkg.sv
// Shared widths, adapter FSM encoding and a constant log2 helper for the bot pipeline.
// Pure declarations: no logic, no latency, no flow control.
package pipelineGlobals;

  localparam int BOT_WIDTH_DEF   = 128;
  localparam int SUM_WIDTH_DEF   = 38;
  localparam int COUNT_WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/opencl_stream_adapter_result_fifo_showahead.sv
// Show-ahead result FIFO: head visible on rd_dat the cycle after its write, zero when empty.
// Write when full is dropped and flagged unless a read frees the slot in the same cycle.
module result_fifo_showahead
  import pipelineGlobals::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic             overflow
);

  localparam int AW = clog2(DEPTH);

  if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_bad_depth
    $error("result_fifo_showahead: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full, rd_fire, wr_fire;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_fire  = rd_rdy && !empty;
  assign wr_fire  = wr_vld && (!full || rd_fire);
  assign overflow = wr_vld && full && !rd_fire;
  assign rd_vld   = !empty;
  assign rd_dat   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/opencl_stream_adapter.sv
// Credit-throttled adapter between the OpenCL stream and the non-stalling bot core; optional OPENCL_ADAPTER_STATS_EN adds stallCycles.
// Bots reach the core one cycle after acceptance; oready drops at FIFO_DEPTH outstanding or while a top drains/loads.
module opencl_stream_adapter
  import pipelineGlobals::*;
#(
  parameter int BOT_WIDTH   = BOT_WIDTH_DEF,
  parameter int SUM_WIDTH   = SUM_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int COUNT_LSB   = 48,
  parameter int OUT_WIDTH   = 64,
  parameter int FIFO_DEPTH  = 32
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ivalid,
  output logic                   oready,
  input  logic                   startNewTop,
  input  logic [BOT_WIDTH-1:0]   botIn,
  output logic                   coreBotValid,
  output logic                   coreTopLoad,
  output logic [BOT_WIDTH-1:0]   coreData,
  input  logic                   coreResultValid,
  input  logic [SUM_WIDTH-1:0]   coreSummedData,
  input  logic [COUNT_WIDTH-1:0] coreCount,
  output logic                   ovalid,
  input  logic                   iready,
  output logic [OUT_WIDTH-1:0]   resultOut,
`ifdef OPENCL_ADAPTER_STATS_EN
  output logic                   overflowErr,
  output logic [31:0]            stallCycles
`else
  output logic                   overflowErr
`endif
);

  localparam int CNT_W = clog2(FIFO_DEPTH) + 1;

  if ((COUNT_LSB < SUM_WIDTH) || (COUNT_LSB + COUNT_WIDTH > OUT_WIDTH)) begin : g_bad_pack
    $error("opencl_stream_adapter: count field overlaps sum or exceeds OUT_WIDTH");
  end

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     outstanding_q;
  logic                 bot_acc_vld, top_acc_vld, out_hs_vld, fifo_ovf;
  logic [OUT_WIDTH-1:0] result_dat;

  assign oready      = (state_q == RUN) && (outstanding_q < CNT_W'(FIFO_DEPTH));
  assign bot_acc_vld = ivalid && oready && !startNewTop;
  assign top_acc_vld = ivalid && oready && startNewTop;
  assign out_hs_vld  = ovalid && iready;

  always_comb begin
    result_dat                          = '0;
    result_dat[SUM_WIDTH-1:0]           = coreSummedData;
    result_dat[COUNT_LSB +: COUNT_WIDTH] = coreCount;
  end

  result_fifo_showahead #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_vld   (coreResultValid),
    .wr_dat   (result_dat),
    .rd_rdy   (iready),
    .rd_vld   (ovalid),
    .rd_dat   (resultOut),
    .overflow (fifo_ovf)
  );

  always_comb begin
    state_d     = state_q;
    coreTopLoad = 1'b0;
    case (state_q)
      RUN: begin
        if (top_acc_vld) state_d = (outstanding_q == '0) ? LOAD : DRAIN;
      end
      DRAIN: begin
        if (outstanding_q == '0) state_d = LOAD;
      end
      LOAD: begin
        coreTopLoad = 1'b1;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // coreData doubles as the pending-top holder: no bot can be accepted between capture and LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      outstanding_q <= '0;
      coreBotValid  <= 1'b0;
      coreData      <= '0;
      overflowErr   <= 1'b0;
    end else begin
      state_q      <= state_d;
      coreBotValid <= bot_acc_vld;
      if (bot_acc_vld || top_acc_vld) coreData <= botIn;
      if (bot_acc_vld && !out_hs_vld)
        outstanding_q <= outstanding_q + CNT_W'(1);
      else if (!bot_acc_vld && out_hs_vld && (outstanding_q != '0))
        outstanding_q <= outstanding_q - CNT_W'(1);
      if (fifo_ovf) overflowErr <= 1'b1;
    end
  end

`ifdef OPENCL_ADAPTER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      stallCycles <= '0;
    else if (ovalid && !iready && (stallCycles != '1))
      stallCycles <= stallCycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_opencl_stream_adapter.sv
// Self-checking bench for opencl_stream_adapter: packing vectors, credit/drain/reset sequences, random traffic vs a queue model.
module tb_opencl_stream_adapter;

  localparam int BW = 128, SW = 38, CW = 3, OW = 64, DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ivalid = 1'b0, startNewTop = 1'b0, iready = 1'b0;
  logic [BW-1:0] botIn = '0;
  logic          oready, coreBotValid, coreTopLoad, ovalid, overflowErr;
  logic [BW-1:0] coreData;
  logic          coreResultValid = 1'b0;
  logic [SW-1:0] coreSummedData = '0;
  logic [CW-1:0] coreCount = '0;
  logic [OW-1:0] resultOut;
`ifdef OPENCL_ADAPTER_STATS_EN
  logic [31:0]   stallCycles;
`endif

  opencl_stream_adapter dut (
    .clk(clk), .rst(rst), .ivalid(ivalid), .oready(oready), .startNewTop(startNewTop),
    .botIn(botIn), .coreBotValid(coreBotValid), .coreTopLoad(coreTopLoad), .coreData(coreData),
    .coreResultValid(coreResultValid), .coreSummedData(coreSummedData), .coreCount(coreCount),
    .ovalid(ovalid), .iready(iready), .resultOut(resultOut),
`ifdef OPENCL_ADAPTER_STATS_EN
    .overflowErr(overflowErr), .stallCycles(stallCycles)
`else
    .overflowErr(overflowErr)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Spec-level packing: sum in the low bits, count at bit 48, everything else zero.
  function automatic logic [OW-1:0] pack(input logic [SW-1:0] s, input logic [CW-1:0] c);
    logic [OW-1:0] w;
    w = '0;
    w[SW-1:0] = s;
    w[48 +: CW] = c;
    return w;
  endfunction

  // The bench's core computes sum from bot bits [37:0] and count from bits [66:64].
  function automatic logic [OW-1:0] pack_bot(input logic [BW-1:0] d);
    return pack(d[SW-1:0], d[64 +: CW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core model: fixed latency, in order, never stalls.
  typedef struct { int due; logic [SW-1:0] sum; logic [CW-1:0] cnt; } pend_t;
  typedef struct { int wcyc; logic [OW-1:0] word; } arr_t;
  pend_t         pend_q[$];
  arr_t          arrive_q[$];
  logic [OW-1:0] exp_q[$];
  int            core_lat = 1;
  logic          inject_req = 1'b0;

  always begin
    @(posedge clk);
    #2;
    coreResultValid = 1'b0;
    if (rst) begin
      pend_q.delete();
    end else begin
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        coreResultValid = 1'b1;
        coreSummedData  = pend_q[0].sum;
        coreCount       = pend_q[0].cnt;
        arrive_q.push_back('{cyc, pack(pend_q[0].sum, pend_q[0].cnt)});
        void'(pend_q.pop_front());
      end else if (inject_req) begin
        coreResultValid = 1'b1;
        coreSummedData  = 38'h15_5555_5555;
        coreCount       = 3'd6;
      end
      if (coreBotValid) pend_q.push_back('{cyc + core_lat, coreData[SW-1:0], coreData[64 +: CW]});
    end
  end

  task automatic do_reset();
    rst = 1'b1; ivalid = 1'b0; startNewTop = 1'b0; iready = 1'b0;
    tick(); tick();
    chk("rst_ovalid", ovalid, 0);
    chk("rst_resultOut", resultOut, 0);
    chk("rst_coreBotValid", coreBotValid, 0);
    chk("rst_coreTopLoad", coreTopLoad, 0);
    chk("rst_coreData", coreData, 0);
    chk("rst_overflowErr", overflowErr, 0);
    chk("rst_oready", oready, 1);
    rst = 1'b0;
    exp_q.delete();
    arrive_q.delete();
  endtask

  task automatic send_bot(input logic [BW-1:0] d);
    int n;
    ivalid = 1'b1; startNewTop = 1'b0; botIn = d;
    n = 0;
    while (!oready && n < 100) begin tick(); n++; end
    if (n >= 100) chk("send_bot_timeout", 1, 0);
    tick();
    ivalid = 1'b0;
    chk("bot_valid_next", coreBotValid, 1);
    chk("bot_data_next", coreData, d);
    exp_q.push_back(pack_bot(d));
  endtask

  task automatic wait_ovalid(input int budget);
    int n;
    n = 0;
    while (!ovalid && n < budget) begin tick(); n++; end
    if (n >= budget) chk("wait_ovalid_timeout", 1, 0);
  endtask

  // Random-phase model: credits = accepted bots not yet handed downstream.
  int            m_cnt;
  bit            m_pend, m_exp_bot;
  int            m_wait0;
  logic [BW-1:0] m_top, m_bot;

  task automatic rand_run(input int ncyc, input bit drain);
    bit ov_exp, or_exp, load_now, hs;
    for (int i = 0; i < ncyc; i++) begin
      chk("r_botvalid", coreBotValid, m_exp_bot);
      if (m_exp_bot) chk("r_botdata", coreData, m_bot);
      load_now = 1'b0;
      if (coreTopLoad) begin
        chk("r_load_legal", (m_pend && m_cnt == 0), 1);
        chk("r_load_data", coreData, m_top);
        load_now = 1'b1;
        m_wait0 = 0;
      end else if (m_pend && m_cnt == 0) begin
        m_wait0++;
        if (m_wait0 > 1) chk("r_load_late", 0, 1);
      end
      ov_exp = arrive_q.size() > 0 && arrive_q[0].wcyc < cyc;
      chk("r_ovalid", ovalid, ov_exp);
      if (ov_exp) chk("r_result", resultOut, arrive_q[0].word);
      or_exp = !m_pend && (m_cnt < DEPTH);
      chk("r_oready", oready, or_exp);
      if (load_now) m_pend = 1'b0;
      iready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      hs = ov_exp && iready;
      if (hs) begin void'(arrive_q.pop_front()); m_cnt--; end
      ivalid = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
      startNewTop = ($urandom_range(0, 39) == 0);
      botIn = {$urandom, $urandom, $urandom, $urandom};
      m_exp_bot = 1'b0;
      if (ivalid && or_exp) begin
        if (startNewTop) begin m_pend = 1'b1; m_top = botIn; end
        else begin m_cnt++; m_exp_bot = 1'b1; m_bot = botIn; end
      end
      tick();
    end
  endtask

  typedef struct { logic [BW-1:0] bot; logic [OW-1:0] word; } vec_t;
  vec_t vecs[6];

  initial begin
    int acc;
    logic [BW-1:0] d, top;

    vecs[0] = '{128'h2_0000_0000_0000_0005,                  64'h0002_0000_0000_0005};
    vecs[1] = '{128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 64'h0007_003F_FFFF_FFFF};
    vecs[2] = '{128'h5_A5A5_A5A5_A5A5_A5A5,                  64'h0005_0025_A5A5_A5A5};
    vecs[3] = '{128'h1,                                      64'h1};
    vecs[4] = '{128'h8_0000_0000_0000_0000,                  64'h0};
    vecs[5] = '{128'h6_0000_0040_0000_0000,                  64'h0006_0000_0000_0000};

    do_reset();

    // Packing vectors, one bot at a time; first one uses the 10-cycle core.
    iready = 1'b1;
    foreach (vecs[i]) begin
      core_lat = (i == 0) ? 10 : 1 + i;
      send_bot(vecs[i].bot);
      wait_ovalid(40);
      chk("vec_result", resultOut, vecs[i].word);
      tick();
      chk("vec_ovalid_one_cycle", ovalid, 0);
      chk("vec_credit_back", oready, 1);
      void'(exp_q.pop_front());
    end

    // Credit limit: 40 offered with downstream stalled, only DEPTH may enter.
    iready = 1'b0; core_lat = 3; acc = 0;
    for (int i = 0; i < 40; i++) begin
      ivalid = 1'b1; startNewTop = 1'b0; botIn = {96'h0, 32'hC0DE_0000 + i};
      botIn[64 +: CW] = 3'(i);
      if (oready) begin acc++; exp_q.push_back(pack_bot(botIn)); end
      tick();
    end
    ivalid = 1'b0;
    chk("credit_accepted", acc, DEPTH);
    chk("credit_oready_low", oready, 0);
    repeat (8) tick();
    chk("credit_fifo_full_valid", ovalid, 1);
    chk("credit_no_ovf", overflowErr, 0);

    // One handshake frees a credit; then accept+handshake together keeps the count.
    iready = 1'b1;
    chk("hs1_result", resultOut, exp_q.pop_front());
    tick();
    iready = 1'b0;
    chk("hs1_oready", oready, 1);
    d = 128'h3_0000_0000_0000_0123;
    ivalid = 1'b1; botIn = d; iready = 1'b1;
    chk("hs2_result", resultOut, exp_q.pop_front());
    exp_q.push_back(pack_bot(d));
    tick();
    ivalid = 1'b0; iready = 1'b0;
    chk("acc_hs_same_cycle_oready", oready, 1);
    d = 128'h4_0000_0000_0000_0456;
    ivalid = 1'b1; botIn = d;
    exp_q.push_back(pack_bot(d));
    tick();
    ivalid = 1'b0;
    chk("credit_refull_oready", oready, 0);
    repeat (8) tick();
    chk("refull_no_ovf", overflowErr, 0);

    // Spurious result while full: dropped and sticky error.
    inject_req = 1'b1;
    tick();
    inject_req = 1'b0;
    tick();
    chk("ovf_set", overflowErr, 1);
    repeat (3) tick();
    chk("ovf_sticky", overflowErr, 1);
    iready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_ovalid", ovalid, 1);
      chk("drain_order", resultOut, exp_q.pop_front());
      tick();
    end
    chk("drain_empty", ovalid, 0);
    chk("drain_oready", oready, 1);
    chk("ovf_still_set", overflowErr, 1);
    do_reset();
    chk("ovf_cleared_by_rst", overflowErr, 0);

    // Top with 4 outstanding: drain, then exactly one load pulse.
    iready = 1'b0; core_lat = 2;
    for (int i = 0; i < 4; i++) send_bot({64'h0, 64'h100 + i});
    repeat (6) tick();
    top = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    ivalid = 1'b1; startNewTop = 1'b1; botIn = top;
    chk("top_accept_oready", oready, 1);
    tick();
    ivalid = 1'b0; startNewTop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_oready_low", oready, 0);
      chk("drain_no_load", coreTopLoad, 0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      iready = 1'b1;
      chk("drain_pop", resultOut, exp_q.pop_front());
      tick();
      iready = 1'b0;
      chk("no_load_before_zero", coreTopLoad, 0);
      if (k < 3) begin tick(); chk("no_load_mid_drain", coreTopLoad, 0); end
    end
    tick();
    chk("load_pulse", coreTopLoad, 1);
    chk("load_data", coreData, top);
    chk("load_oready_low", oready, 0);
    tick();
    chk("load_one_cycle", coreTopLoad, 0);
    chk("run_after_load", oready, 1);

    // Top with nothing outstanding loads on the next cycle.
    top = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    ivalid = 1'b1; startNewTop = 1'b1; botIn = top;
    tick();
    ivalid = 1'b0; startNewTop = 1'b0;
    chk("direct_load", coreTopLoad, 1);
    chk("direct_load_data", coreData, top);
    tick();
    chk("direct_load_done", coreTopLoad, 0);
    chk("direct_run", oready, 1);

    // Reset in DRAIN with 3 results buffered.
    for (int i = 0; i < 3; i++) send_bot({64'h0, 64'h200 + i});
    repeat (6) tick();
    chk("pre_rst_ovalid", ovalid, 1);
    ivalid = 1'b1; startNewTop = 1'b1; botIn = 128'hABCD;
    tick();
    ivalid = 1'b0; startNewTop = 1'b0;
    chk("pre_rst_drain", oready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_drain_ovalid", ovalid, 0);
    chk("rst_drain_oready", oready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("rst_drain_no_load", coreTopLoad, 0);
      tick();
    end
    exp_q.delete(); arrive_q.delete();

    // Random traffic against the queue model.
    do_reset();
    m_cnt = 0; m_pend = 1'b0; m_exp_bot = 1'b0; m_wait0 = 0;
    for (int r = 0; r < 4; r++) begin
      core_lat = $urandom_range(1, 12);
      rand_run(500, 1'b0);
      rand_run(60, 1'b1);
    end
    chk("rand_end_empty", ovalid, 0);
    chk("rand_end_oready", oready, 1);
    chk("rand_no_ovf", overflowErr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
